midi_note_gen: RTL and testbench



---
 rtl/midi_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 50 +++++
 rtl/midi_note_gen.sv | 148 ++++++++++++++
 tb/tb_midi_note_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI note generator.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;

  typedef enum logic {
    EV_PRESS   = 1'b0,
    EV_RELEASE = 1'b1
  } midi_ev_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATUS = 2'd1,
    ST_DATA1  = 2'd2,
    ST_DATA2  = 2'd3
  } note_state_t;

  // Status byte: message type in the high nibble, channel in the low nibble.
  function automatic logic [7:0] status_byte(input midi_ev_t ev, input logic [3:0] ch);
    return {(ev == EV_PRESS) ? MIDI_NOTE_ON : MIDI_NOTE_OFF, ch};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a hold-time debouncer producing a clean level.
// Latency: stable_o follows a held input change DEBOUNCE_CNT+1 edges after first sampling it.
// Backpressure: none; free-running, any shorter glitch is discarded.
module btn_debounce #(
  parameter int DEBOUNCE_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic stable_o
);

  // A DEBOUNCE_CNT of 1 still needs a 1-bit counter to stay legal.
  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);

  logic          s1_q;
  logic          s2_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

  // Accept a new level only after it has been seen for DEBOUNCE_CNT consecutive cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else if (s2_q == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_q <= s2_q;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/midi_note_gen.sv
// Turns debounced button presses/releases into 3-byte MIDI Note On/Off messages.
// Latency: first byte valid DEBOUNCE_CNT+3 edges after the button is first sampled held.
// Backpressure: bytes hold until tx_ready; a 2-entry event queue buffers, extra events set overflow.
module midi_note_gen
  import midi_pkg::*;
#(
  parameter int         DEBOUNCE_CNT = 1_000_000,
  parameter logic [3:0] CHANNEL      = 4'd0,
  parameter logic [7:0] NOTE         = 8'h3C,
  parameter logic [7:0] VELOCITY     = 8'h64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       led,
  output logic       overflow
);

  logic        stable;
  logic        stable_q;
  logic        push;
  midi_ev_t    push_ev;
  logic        push_ok;
  logic        pop;
  logic        empty;
  logic        full;
  logic [1:0]  fifo_q;
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  cnt_q;
  midi_ev_t    head_ev;
  logic        overflow_q;

  note_state_t state_q;
  midi_ev_t    ev_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic        led_q;
  logic        hs;

  btn_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn),
    .stable_o(stable)
  );

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stable_q <= 1'b0;
    else      stable_q <= stable;
  end

  // A change in the debounced level is an event: rising is PRESS, falling is RELEASE.
  assign push    = stable ^ stable_q;
  assign push_ev = stable ? EV_PRESS : EV_RELEASE;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'd2);
  assign pop     = (state_q == ST_IDLE) && !empty;
  // A simultaneous pop frees a slot, so a push into a full queue still lands.
  assign push_ok = push && (!full || pop);
  assign head_ev = midi_ev_t'(fifo_q[rd_ptr_q]);
  assign hs      = tx_valid_q && tx_ready;

  // Two-entry event queue with a sticky overflow flag for dropped events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q     <= 2'b00;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= push_ev;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  // Message sequencer: pops one event and emits its three bytes with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ev_q       <= EV_PRESS;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      led_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            state_q    <= ST_STATUS;
            ev_q       <= head_ev;
            tx_valid_q <= 1'b1;
            tx_data_q  <= status_byte(head_ev, CHANNEL);
            led_q      <= 1'b1;
          end
        end
        ST_STATUS: begin
          if (hs) begin
            state_q   <= ST_DATA1;
            tx_data_q <= {1'b0, NOTE[6:0]};
          end
        end
        ST_DATA1: begin
          if (hs) begin
            state_q   <= ST_DATA2;
            tx_data_q <= (ev_q == EV_PRESS) ? {1'b0, VELOCITY[6:0]} : 8'h00;
          end
        end
        ST_DATA2: begin
          if (hs) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            led_q      <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
          tx_data_q  <= 8'h00;
          led_q      <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign led      = led_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_midi_note_gen.sv
// Directed bench for midi_note_gen with a short debounce window.
// Latency: checks exact first-byte timing, stall holding and reset behaviour.
// Backpressure: drives tx_ready directly to stall the byte stream.
module tb_midi_note_gen;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       led;
  logic       overflow;
  logic [7:0] tx_data5;
  logic       tx_valid5;
  logic       led5;
  logic       overflow5;

  int n_assert = 0;
  int n_fail   = 0;
  logic seen;

  midi_note_gen #(
    .DEBOUNCE_CNT(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .led     (led),
    .overflow(overflow)
  );

  // Same stimulus, channel 5: only the status byte low nibble differs.
  midi_note_gen #(
    .DEBOUNCE_CNT(8),
    .CHANNEL     (4'd5)
  ) dut5 (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .tx_data (tx_data5),
    .tx_valid(tx_valid5),
    .tx_ready(tx_ready),
    .led     (led5),
    .overflow(overflow5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int i;
    i = 0;
    while (tx_valid !== 1'b1 && i < max_cycles) begin
      tick();
      i++;
    end
    check(tag, {7'd0, tx_valid}, 8'h01);
  endtask

  // Expects the three bytes on consecutive cycles with tx_ready held high.
  task automatic expect_msg(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
    check({tag, "_b0"}, tx_data, b0);
    check({tag, "_v0"}, {7'd0, tx_valid}, 8'h01);
    tick();
    check({tag, "_b1"}, tx_data, b1);
    check({tag, "_v1"}, {7'd0, tx_valid}, 8'h01);
    tick();
    check({tag, "_b2"}, tx_data, b2);
    check({tag, "_v2"}, {7'd0, tx_valid}, 8'h01);
    tick();
  endtask

  initial begin
    rst      = 1'b0;
    btn      = 1'b0;
    tx_ready = 1'b1;
    seen     = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_valid", {7'd0, tx_valid}, 8'h00);
    check("rst_data", tx_data, 8'h00);
    check("rst_led", {7'd0, led}, 8'h00);
    check("rst_ovf", {7'd0, overflow}, 8'h00);
    rst = 1'b1;
    tick();

    // Press: first byte valid right after edge 11
    btn = 1'b1;
    repeat (11) tick();
    check("t1_pre_valid", {7'd0, tx_valid}, 8'h00);
    check("t1_pre_led", {7'd0, led}, 8'h00);
    tick();
    check("t1_led0", {7'd0, led}, 8'h01);
    check("t1_ch5_status", tx_data5, 8'h95);
    check("t1_ch5_valid", {7'd0, tx_valid5}, 8'h01);
    expect_msg("t1_on", 8'h90, 8'h3C, 8'h64);
    check("t1_post_valid", {7'd0, tx_valid}, 8'h00);
    check("t1_post_led", {7'd0, led}, 8'h00);

    // Release
    btn = 1'b0;
    wait_valid("t2_wait", 20);
    check("t2_ch5_status", tx_data5, 8'h85);
    expect_msg("t2_off", 8'h80, 8'h3C, 8'h00);
    check("t2_post_valid", {7'd0, tx_valid}, 8'h00);

    // Bounce: pulses of 1..7 cycles never make it through
    seen = 1'b0;
    for (int p = 1; p <= 7; p++) begin
      btn = 1'b1;
      for (int k = 0; k < p; k++) begin
        tick();
        seen = seen | tx_valid;
      end
      btn = 1'b0;
      for (int k = 0; k < 6; k++) begin
        tick();
        seen = seen | tx_valid;
      end
    end
    for (int k = 0; k < 15; k++) begin
      tick();
      seen = seen | tx_valid;
    end
    check("t3_no_valid", {7'd0, seen}, 8'h00);
    check("t3_no_ovf", {7'd0, overflow}, 8'h00);

    // Stall in DATA1 for 5 cycles
    btn = 1'b1;
    wait_valid("t4_wait", 20);
    check("t4_status", tx_data, 8'h90);
    tick();
    check("t4_data1", tx_data, 8'h3C);
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_hold_data", tx_data, 8'h3C);
      check("t4_hold_valid", {7'd0, tx_valid}, 8'h01);
    end
    tx_ready = 1'b1;
    tick();
    check("t4_data2", tx_data, 8'h64);
    check("t4_data2_valid", {7'd0, tx_valid}, 8'h01);
    tick();
    check("t4_post_valid", {7'd0, tx_valid}, 8'h00);
    btn = 1'b0;
    wait_valid("t4_rel_wait", 20);
    expect_msg("t4_off", 8'h80, 8'h3C, 8'h00);

    // Queue fill and overflow while stalled on the first status byte
    tx_ready = 1'b0;
    btn = 1'b1;
    wait_valid("t5_wait", 20);
    check("t5_status", tx_data, 8'h90);
    btn = 1'b0;
    repeat (12) tick();
    btn = 1'b1;
    repeat (12) tick();
    check("t5_ovf_before", {7'd0, overflow}, 8'h00);
    check("t5_still_status", tx_data, 8'h90);
    btn = 1'b0;
    repeat (12) tick();
    check("t5_ovf_after", {7'd0, overflow}, 8'h01);
    check("t5_ch5_ovf", {7'd0, overflow5}, 8'h01);
    tx_ready = 1'b1;
    expect_msg("t5_m1", 8'h90, 8'h3C, 8'h64);
    check("t5_gap1", {7'd0, tx_valid}, 8'h00);
    tick();
    check("t5_m2_valid", {7'd0, tx_valid}, 8'h01);
    expect_msg("t5_m2", 8'h80, 8'h3C, 8'h00);
    check("t5_gap2", {7'd0, tx_valid}, 8'h00);
    tick();
    check("t5_m3_valid", {7'd0, tx_valid}, 8'h01);
    expect_msg("t5_m3", 8'h90, 8'h3C, 8'h64);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      seen = seen | tx_valid;
    end
    check("t5_no_fourth", {7'd0, seen}, 8'h00);
    check("t5_ovf_sticky", {7'd0, overflow}, 8'h01);

    // Reset during DATA1, button held through reset
    btn = 1'b1;
    wait_valid("t6_wait", 20);
    check("t6_status", tx_data, 8'h90);
    tick();
    check("t6_data1", tx_data, 8'h3C);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_valid", {7'd0, tx_valid}, 8'h00);
    check("t6_rst_data", tx_data, 8'h00);
    check("t6_rst_led", {7'd0, led}, 8'h00);
    check("t6_rst_ovf", {7'd0, overflow}, 8'h00);
    repeat (3) tick();
    rst = 1'b1;
    wait_valid("t6_fresh_wait", 30);
    expect_msg("t6_fresh", 8'h90, 8'h3C, 8'h64);
    check("t6_post_valid", {7'd0, tx_valid}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
